blockram_reader: RTL and testbench

Bus initiator that streams a contiguous address range out of a `BlockRam` instance (8-bit address, 16-bit data, registered enable) to a downstream consumer. It drives the RAM's `Addr`/`En`/`Rd`/`Wr` pins and matches the RAM's two-cycle read pipeline. Returned words pass through a 4-entry skid FIFO, which presents them on a valid/ready port with full backpressure. It sits between a `BlockRam` holding waveform or table data and any Xport logic that consumes 16-bit words sequentially.

---
 rtl/blockram_reader.sv | 199 +++++++++++++++++++
 tb/tb_blockram_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_reader.sv
// blockram_reader: streams a contiguous BlockRam address range through a skid FIFO
// onto a valid/ready port. Define XPORT_BRREADER_LOOP_EN to repeat the range until Abort/Reset.
module blockram_reader #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  StartAddr,
    input  logic [7:0]  EndAddr,
    input  logic        Abort,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  RamAddr,
    output logic        RamEn,
    output logic        RamRd,
    output logic        RamWr,
    input  logic [15:0] RamData,
    output logic [15:0] OutData,
    output logic        OutValid,
    input  logic        OutReady
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned InfW = $clog2(LAT + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} stateT;

    stateT stateQ, stateD;
    logic [7:0] issueAddrQ, issueAddrD;
    logic [8:0] remainingQ, remainingD;
    logic [7:0] ramAddrQ;
    logic       doneQ, doneD;

`ifdef XPORT_BRREADER_LOOP_EN
    logic [7:0] startAddrQ;
    logic [8:0] rangeLenQ;
`endif

    // Return pipeline: one valid/last bit per read in flight.
    logic [LAT-1:0] vldQ;
    logic [LAT-1:0] lastQ;

    logic [DEPTH-1:0][15:0] dataMemQ;
    logic [DEPTH-1:0]       lastMemQ;
    logic [PtrW-1:0]        wrPtrQ, rdPtrQ;
    logic [CntW-1:0]        cntQ;

    logic [InfW-1:0] inflight;
    logic            credit;
    logic            issue;
    logic            issueLast;
    logic            push;
    logic            pop;
    logic            headLast;
    logic [8:0]      rangeLen;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + InfW'(vldQ[i]);
        end
    end

    assign rangeLen  = {1'b0, 8'(EndAddr - StartAddr)} + 9'd1;
    assign credit    = (32'(cntQ) + 32'(inflight)) < DEPTH;
    assign issue     = (stateQ == StFetch) && (remainingQ != 9'd0) && credit && !Abort;
    assign issueLast = (remainingQ == 9'd1);
    assign push      = vldQ[LAT-1];
    assign OutValid  = (cntQ != '0);
    assign pop       = OutValid && OutReady;
    assign headLast  = lastMemQ[rdPtrQ];
    assign OutData   = dataMemQ[rdPtrQ];

    assign Busy    = (stateQ != StIdle);
    assign Done    = doneQ;
    assign RamEn   = issue;
    assign RamRd   = issue;
    assign RamWr   = 1'b0;
    assign RamAddr = ramAddrQ;

    always_comb begin
        stateD     = stateQ;
        issueAddrD = issueAddrQ;
        remainingD = remainingQ;
        doneD      = !Abort && pop && headLast;
        if (Abort) begin
            stateD = StIdle;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (Start) begin
                        stateD     = StFetch;
                        issueAddrD = StartAddr;
                        remainingD = rangeLen;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        issueAddrD = issueAddrQ + 8'd1;
                        remainingD = remainingQ - 9'd1;
                        if (issueLast) begin
`ifdef XPORT_BRREADER_LOOP_EN
                            issueAddrD = startAddrQ;
                            remainingD = rangeLenQ;
`else
                            stateD = StDrain;
`endif
                        end
                    end
                end
                StDrain: begin
                    // The flagged last word leaving the FIFO ends the pass.
                    if (pop && headLast) begin
                        stateD = StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ     <= StIdle;
            issueAddrQ <= '0;
            remainingQ <= '0;
            ramAddrQ   <= '0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            issueAddrQ <= issueAddrD;
            remainingQ <= remainingD;
            doneQ      <= doneD;
            // BlockRam registers En but samples Addr a cycle later.
            if (issue) begin
                ramAddrQ <= issueAddrQ;
            end
        end
    end

`ifdef XPORT_BRREADER_LOOP_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            startAddrQ <= '0;
            rangeLenQ  <= '0;
        end else if ((stateQ == StIdle) && Start && !Abort) begin
            startAddrQ <= StartAddr;
            rangeLenQ  <= rangeLen;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vldQ  <= '0;
            lastQ <= '0;
        end else if (Abort) begin
            vldQ  <= '0;
            lastQ <= '0;
        end else begin
            vldQ  <= (vldQ << 1) | LAT'(issue);
            lastQ <= (lastQ << 1) | LAT'(issue && issueLast);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dataMemQ <= '0;
            lastMemQ <= '0;
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            cntQ     <= '0;
        end else if (Abort) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (push) begin
                dataMemQ[wrPtrQ] <= RamData;
                lastMemQ[wrPtrQ] <= lastQ[LAT-1];
                wrPtrQ           <= ptrInc(wrPtrQ);
            end
            if (pop) begin
                rdPtrQ <= ptrInc(rdPtrQ);
            end
            case ({push, pop})
                2'b10:   cntQ <= cntQ + 1'b1;
                2'b01:   cntQ <= cntQ - 1'b1;
                default: cntQ <= cntQ;
            endcase
        end
    end
endmodule

// File: tb/tb_blockram_reader.sv
// Randomised scoreboard bench for blockram_reader with a behavioural BlockRam model.
// Define XPORT_BRREADER_LOOP_EN to exercise the looping build instead of single passes.
module tb_blockram_reader;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset, Start, Abort, OutReady;
    logic [7:0]  StartAddr, EndAddr;
    logic        Busy, Done, RamEn, RamRd, RamWr, OutValid;
    logic [7:0]  RamAddr;
    logic [15:0] RamData, OutData;

    always #5 Clk = ~Clk;

    blockram_reader #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .EndAddr(EndAddr),
        .Abort(Abort), .Busy(Busy), .Done(Done), .RamAddr(RamAddr), .RamEn(RamEn),
        .RamRd(RamRd), .RamWr(RamWr), .RamData(RamData), .OutData(OutData),
        .OutValid(OutValid), .OutReady(OutReady)
    );

    // BlockRam: En registered, Addr sampled unregistered one cycle later.
    logic [15:0] mem [256];
    logic        ramEnQ = 1'b0;
    always @(posedge Clk) begin
        ramEnQ <= RamEn;
        if (ramEnQ) RamData <= mem[RamAddr];
    end

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } expT;

    expT expQ[$];
    expT monItem;
    int  errors = 0;
    int  checks = 0;
    bit  expDone = 0;
    int  outstanding = 0;
    bit  loopMode = 0;
    bit  rndReady = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word, tracks Done and outstanding reads.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("RamWr low", RamWr, 0);
            check("RamRd follows RamEn", RamRd, RamEn);
            check("Done pulse", Done, expDone);
            if (expDone && !loopMode) check("Busy low with Done", Busy, 0);
            expDone = 0;
            if (!Abort) begin
                if (RamEn) outstanding++;
                if (OutValid && OutReady) begin
                    outstanding--;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected word: got %0h, required none", OutData);
                    end else begin
                        monItem = expQ.pop_front();
                        check("OutData", OutData, monItem.data);
                        expDone = monItem.last;
                    end
                end
                checks++;
                if (outstanding > int'(DEPTH)) begin
                    errors++;
                    $display("FAIL outstanding reads: got %0d, required <= %0d", outstanding,
                             DEPTH);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rndReady) OutReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic flushModel();
        expQ.delete();
        outstanding = 0;
        expDone     = 0;
    endtask

    task automatic pushRange(input logic [7:0] s, input logic [7:0] e, input int passes);
        int  len;
        expT it;
        len = ((int'(e) - int'(s)) & 255) + 1;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < len; k++) begin
                it.data = mem[8'(int'(s) + k)];
                it.last = (k == len - 1);
                expQ.push_back(it);
            end
        end
    endtask

    // Leaves the bench just after the edge that samples Start.
    task automatic startPass(input logic [7:0] s, input logic [7:0] e);
        pushRange(s, e, 1);
        Start     = 1'b1;
        StartAddr = s;
        EndAddr   = e;
        tick();
        Start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        while ((Busy || expQ.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check({name, " completes"}, {31'd0, (!Busy && expQ.size() == 0)}, 1);
        tick();
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, " Busy"}, Busy, 0);
        check({name, " Done"}, Done, 0);
        check({name, " RamEn"}, RamEn, 0);
        check({name, " RamRd"}, RamRd, 0);
        check({name, " RamWr"}, RamWr, 0);
        check({name, " OutValid"}, OutValid, 0);
        check({name, " RamAddr"}, RamAddr, 0);
        check({name, " OutData"}, OutData, 0);
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Abort     = 1'b0;
        OutReady  = 1'b1;
        StartAddr = '0;
        EndAddr   = '0;
        for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);
        tick();
        tick();
        checkResetOutputs("reset");
        Reset = 1'b0;
        tick();

`ifdef XPORT_BRREADER_LOOP_EN
        loopMode = 1;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        rndReady = 1;
        startPass(8'h00, 8'h02);
        pushRange(8'h00, 8'h02, 29);
        for (int n = 0; n < 400 && expQ.size() > 6; n++) begin
            check("loop Busy held", Busy, 1);
            tick();
        end
        check("loop progressed", {31'd0, expQ.size() <= 6}, 1);
        rndReady = 0;
        Abort    = 1'b1;
        tick();
        Abort = 1'b0;
        flushModel();
        check("loop abort Busy", Busy, 0);
        check("loop abort OutValid", OutValid, 0);
        repeat (8) tick();
        check("loop stays stopped", Busy, 0);
`else
        // Basic pass with cycle-exact latency.
        OutReady = 1'b1;
        startPass(8'h10, 8'h13);
        check("Busy cycle 1", Busy, 1);
        check("RamEn cycle 1", RamEn, 1);
        tick();
        check("RamAddr skewed", RamAddr, 8'h10);
        tick();
        check("OutValid before fill", OutValid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("basic OutValid streaming", OutValid, 1);
            check("basic OutData order", OutData, 32'hA010 + 32'(i));
            tick();
        end
        check("basic Done", Done, 1);
        check("basic Busy falls", Busy, 0);
        tick();
        check("basic Done single", Done, 0);

        // Wrap and range boundaries.
        startPass(8'hFE, 8'h01);
        waitIdle("wrap", 60);
        startPass(8'h20, 8'h20);
        waitIdle("single word", 60);
        startPass(8'h00, 8'hFF);
        waitIdle("full range", 600);

        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);

        // Backpressure, with a Start during Busy that must be ignored.
        startPass(8'h30, 8'h3F);
        tick();
        tick();
        Start     = 1'b1;
        StartAddr = 8'h99;
        EndAddr   = 8'h9A;
        OutReady  = 1'b0;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check("backpressure RamEn stalls", RamEn, 0);
        check("backpressure OutValid held", OutValid, 1);
        OutReady = 1'b1;
        waitIdle("backpressure", 100);

        // Abort two cycles after Start.
        startPass(8'h40, 8'h4F);
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        flushModel();
        check("abort OutValid", OutValid, 0);
        check("abort Busy", Busy, 0);
        check("abort Done", Done, 0);
        repeat (8) tick();
        check("abort no late words", OutValid, 0);
        startPass(8'h80, 8'h83);
        waitIdle("after abort", 60);

        // Randomised passes with random backpressure.
        rndReady = 1;
        for (int r = 0; r < 8; r++) begin
            logic [7:0] s;
            int         len;
            s   = 8'($urandom);
            len = $urandom_range(1, 40);
            startPass(s, 8'(int'(s) + len - 1));
            waitIdle("random pass", 400);
            repeat ($urandom_range(0, 3)) tick();
        end
        rndReady = 0;
        OutReady = 1'b1;

        // Asynchronous reset between edges mid-pass.
        startPass(8'h50, 8'h6F);
        repeat (5) tick();
        #2;
        Reset = 1'b1;
        #1;
        checkResetOutputs("async reset");
        flushModel();
        tick();
        Reset = 1'b0;
        tick();
        startPass(8'h05, 8'h07);
        waitIdle("after reset", 60);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
